ds_scale_ctrl: RTL and testbench

Timing and sequencing controller for the NxN averaging downscaler datapath. It tracks the incoming vsync/hsync/de stream and generates the line-buffer write enable and address, window-phase counters, the output-valid strobe and output coordinates. It also shadows a run-time scale-factor configuration so changes apply only at frame boundaries. It sits between the video timing source and the downscaler window/averaging datapath, and flags malformed line or frame lengths.

---
 rtl/ds_scale_ctrl_pkg.sv | 30 +++
 rtl/ds_scale_ctrl_if.sv | 12 +
 rtl/ds_scale_ctrl_sync_edge.sv | 26 ++
 rtl/ds_scale_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_ds_scale_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/ds_scale_ctrl_pkg.sv
// Shared types and helpers for the downscaler sequencing controller.
package ds_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    ACTIVE  = 2'd2,
    DONE    = 2'd3
  } ds_state_e;

  localparam int ERR_HLEN = 0;
  localparam int ERR_VLEN = 1;
  localparam int ERR_CFG  = 2;

  function automatic logic factor_bad(input logic [7:0] f, input logic [7:0] maxf);
    return (f == 8'd0) || (f > maxf);
  endfunction

  // Out-of-range factors fall back to 1 (pass-through).
  function automatic logic [7:0] clamp_factor(input logic [7:0] f, input logic [7:0] maxf);
    logic [7:0] r;
    if (factor_bad(f, maxf)) begin
      r = 8'd1;
    end else begin
      r = f;
    end
    return r;
  endfunction

endpackage

// File: rtl/ds_scale_ctrl_if.sv
// Run-time configuration handshake between the host and the scaler controller.
interface ds_scale_ctrl_if #(
  parameter int MAXF = 4
);
  logic                       cfg_valid;
  logic                       cfg_ready;
  logic                       cfg_en;
  logic [$clog2(MAXF+1)-1:0]  cfg_factor;

  modport master (output cfg_valid, output cfg_en, output cfg_factor, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_en, input cfg_factor, output cfg_ready);
endinterface

// File: rtl/ds_scale_ctrl_sync_edge.sv
// One-cycle registered copy of a sync/enable bundle with rise and fall pulses.
module ds_sync_edge #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] din_r;

  // Delayed copy used for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      din_r <= {W{1'b0}};
    end else begin
      din_r <= din;
    end
  end

  assign rise = din & ~din_r;
  assign fall = ~din & din_r;

endmodule

// File: rtl/ds_scale_ctrl.sv
// Sequencing controller for the NxN averaging downscaler: line-buffer addressing,
// window phases, output strobe/coordinates, frame-aligned config and length checks.
module ds_scale_ctrl
  import ds_pkg::*;
#(
  parameter int HACT = 10,
  parameter int VACT = 10,
  parameter int MAXF = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       i_vsync,
  input  logic                       i_hsync,
  input  logic                       i_de,
  ds_scale_ctrl_if.slave             cfg,
  output logic                       o_lb_wen,
  output logic [$clog2(HACT)-1:0]    o_lb_addr,
  output logic [$clog2(MAXF)-1:0]    o_col_ph,
  output logic [$clog2(MAXF)-1:0]    o_row_ph,
  output logic                       o_out_valid,
  output logic [$clog2(HACT)-1:0]    o_ox,
  output logic [$clog2(VACT)-1:0]    o_oy,
  output logic [$clog2(MAXF+1)-1:0]  o_factor,
  output logic                       o_active,
  output logic [2:0]                 o_err
);

  localparam int PW = $clog2(HACT);
  localparam int VW = $clog2(VACT);
  localparam int CW = $clog2(MAXF);
  localparam int FW = $clog2(MAXF+1);

  logic [2:0]    rise_s, fall_s;
  logic          vs_rise_s, de_fall_s, edge_unused_s;
  ds_state_e     state_r, state_s;
  logic          pend_r, cfg_ready_r, shad_en_r, act_en_r;
  logic [FW-1:0] shad_factor_r, act_factor_r, fm1_s;
  logic [2:0]    err_r;
  logic [PW-1:0] p_cnt_r, ox_r;
  logic [VW-1:0] v_cnt_r, oy_r;
  logic [CW-1:0] col_ph_r, row_ph_r;
  logic          accept_s, apply_s, cfg_bad_s, active_s, lb_wen_s, out_valid_s;
  logic          col_last_s, row_last_s, p_last_s, hlen_err_s, vlen_err_s;

  ds_sync_edge #(.W(3)) u_edge (
    .clk  (clk),
    .rstn (rstn),
    .din  ({i_vsync, i_hsync, i_de}),
    .rise (rise_s),
    .fall (fall_s)
  );

  assign vs_rise_s     = rise_s[2];
  assign de_fall_s     = fall_s[0];
  assign edge_unused_s = ^{rise_s[1:0], fall_s[2:1]};

  assign accept_s    = cfg.cfg_valid & cfg_ready_r;
  assign apply_s     = vs_rise_s & pend_r;
  assign cfg_bad_s   = factor_bad(8'(cfg.cfg_factor), 8'(MAXF));
  assign active_s    = (state_r == ACTIVE);
  assign lb_wen_s    = i_de & active_s;
  assign fm1_s       = act_factor_r - FW'(1'b1);
  assign col_last_s  = (FW'(col_ph_r) == fm1_s);
  assign row_last_s  = (FW'(row_ph_r) == fm1_s);
  assign p_last_s    = (p_cnt_r == PW'(HACT-1));
  assign out_valid_s = lb_wen_s & col_last_s & row_last_s;
  assign hlen_err_s  = active_s & de_fall_s & (p_cnt_r != {PW{1'b0}});
  assign vlen_err_s  = (active_s & vs_rise_s) | ((state_r == DONE) & i_de);

  // Shadow/active config; ready is low exactly while a write awaits the next vsync.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_r        <= 1'b0;
      cfg_ready_r   <= 1'b1;
      shad_en_r     <= 1'b0;
      shad_factor_r <= {FW{1'b0}};
      act_en_r      <= 1'b0;
      act_factor_r  <= {FW{1'b0}};
    end else if (accept_s) begin
      pend_r        <= 1'b1;
      cfg_ready_r   <= 1'b0;
      shad_en_r     <= cfg.cfg_en;
      shad_factor_r <= FW'(clamp_factor(8'(cfg.cfg_factor), 8'(MAXF)));
    end else if (apply_s) begin
      pend_r        <= 1'b0;
      cfg_ready_r   <= 1'b1;
      act_en_r      <= shad_en_r;
      act_factor_r  <= shad_factor_r;
    end
  end

  // Sticky error flags, restarted by every accepted config write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_r <= 3'b000;
    end else if (accept_s) begin
      err_r[ERR_CFG]  <= cfg_bad_s;
      err_r[ERR_VLEN] <= 1'b0;
      err_r[ERR_HLEN] <= 1'b0;
    end else begin
      if (hlen_err_s) err_r[ERR_HLEN] <= 1'b1;
      if (vlen_err_s) err_r[ERR_VLEN] <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state; applying a disabling config overrides every other transition.
  always_comb begin
    state_s = state_r;
    if (apply_s && !shad_en_r) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    if (act_en_r) state_s = WAIT_VS; else state_s = IDLE;
        WAIT_VS: if (vs_rise_s) state_s = ACTIVE; else state_s = WAIT_VS;
        ACTIVE:  if (de_fall_s && (v_cnt_r == VW'(VACT-1))) state_s = DONE; else state_s = ACTIVE;
        DONE:    if (vs_rise_s) state_s = ACTIVE; else state_s = DONE;
        default: state_s = IDLE;
      endcase
    end
  end

  // Pixel/line counters and output coordinates; de fall also resyncs the pixel pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_cnt_r  <= {PW{1'b0}};
      v_cnt_r  <= {VW{1'b0}};
      col_ph_r <= {CW{1'b0}};
      row_ph_r <= {CW{1'b0}};
      ox_r     <= {PW{1'b0}};
      oy_r     <= {VW{1'b0}};
    end else if (vs_rise_s) begin
      p_cnt_r  <= {PW{1'b0}};
      v_cnt_r  <= {VW{1'b0}};
      col_ph_r <= {CW{1'b0}};
      row_ph_r <= {CW{1'b0}};
      ox_r     <= {PW{1'b0}};
      oy_r     <= {VW{1'b0}};
    end else if (active_s) begin
      if (i_de) begin
        if (p_last_s) begin
          p_cnt_r  <= {PW{1'b0}};
          col_ph_r <= {CW{1'b0}};
          ox_r     <= {PW{1'b0}};
        end else begin
          p_cnt_r  <= p_cnt_r + PW'(1'b1);
          col_ph_r <= col_last_s ? {CW{1'b0}} : col_ph_r + CW'(1'b1);
          if (out_valid_s) ox_r <= ox_r + PW'(1'b1);
        end
      end
      if (de_fall_s) begin
        p_cnt_r  <= {PW{1'b0}};
        col_ph_r <= {CW{1'b0}};
        ox_r     <= {PW{1'b0}};
        v_cnt_r  <= v_cnt_r + VW'(1'b1);
        row_ph_r <= row_last_s ? {CW{1'b0}} : row_ph_r + CW'(1'b1);
        if (row_last_s) oy_r <= oy_r + VW'(1'b1);
      end
    end
  end

  assign cfg.cfg_ready = cfg_ready_r;
  assign o_lb_wen      = lb_wen_s;
  assign o_lb_addr     = p_cnt_r;
  assign o_col_ph      = col_ph_r;
  assign o_row_ph      = row_ph_r;
  assign o_out_valid   = out_valid_s;
  assign o_ox          = ox_r;
  assign o_oy          = oy_r;
  assign o_factor      = act_factor_r;
  assign o_active      = active_s;
  assign o_err         = err_r;

endmodule

// File: tb/tb_ds_scale_ctrl.sv
// Scoreboard bench for ds_scale_ctrl with a 6x6 active frame and factors 1..4.
module tb_ds_scale_ctrl;

  localparam int HACT = 6;
  localparam int VACT = 6;
  localparam int MAXF = 4;

  typedef struct packed {
    logic [2:0] addr;
    logic [2:0] ox;
    logic [2:0] oy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       i_vsync = 1'b0, i_hsync = 1'b0, i_de = 1'b0;
  logic       o_lb_wen, o_out_valid, o_active;
  logic [2:0] o_lb_addr, o_ox, o_oy, o_factor, o_err;
  logic [1:0] o_col_ph, o_row_ph;

  int   checks = 0;
  int   failures = 0;
  int   lb_cnt = 0;
  int   lb0;
  exp_t exp_q[$];
  exp_t mon_e;

  ds_scale_ctrl_if #(.MAXF(MAXF)) cfg_if ();

  ds_scale_ctrl #(.HACT(HACT), .VACT(VACT), .MAXF(MAXF)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_vsync     (i_vsync),
    .i_hsync     (i_hsync),
    .i_de        (i_de),
    .cfg         (cfg_if),
    .o_lb_wen    (o_lb_wen),
    .o_lb_addr   (o_lb_addr),
    .o_col_ph    (o_col_ph),
    .o_row_ph    (o_row_ph),
    .o_out_valid (o_out_valid),
    .o_ox        (o_ox),
    .o_oy        (o_oy),
    .o_factor    (o_factor),
    .o_active    (o_active),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: pops the expected window for every output strobe.
  always @(negedge clk) begin
    if (rstn) begin
      if (o_lb_wen) lb_cnt++;
      if (o_out_valid) begin
        if (exp_q.size() == 0) begin
          chk("pulse_expected", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pulse_addr", o_lb_addr, mon_e.addr);
          chk("pulse_ox", o_ox, mon_e.ox);
          chk("pulse_oy", o_oy, mon_e.oy);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int a, input int x, input int y);
    exp_q.push_back('{addr: 3'(a), ox: 3'(x), oy: 3'(y)});
  endtask

  task automatic line(input int n);
    for (int i = 0; i < n; i++) begin
      i_de = 1'b1;
      tick();
    end
    i_de = 1'b0;
    i_hsync = 1'b1;
    tick();
    i_hsync = 1'b0;
    tick();
  endtask

  task automatic vsync_pulse();
    i_vsync = 1'b1;
    tick();
    i_vsync = 1'b0;
    tick();
    tick();
  endtask

  task automatic cfg_write(input logic en, input logic [2:0] f);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_en     = en;
    cfg_if.cfg_factor = f;
    tick();
    cfg_if.cfg_valid  = 1'b0;
  endtask

  initial begin
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_en     = 1'b0;
    cfg_if.cfg_factor = 3'd0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_cfg_ready", cfg_if.cfg_ready, 1);
    chk("rst_active", o_active, 0);
    chk("rst_factor", o_factor, 0);
    chk("rst_err", o_err, 0);
    chk("rst_lb_wen", o_lb_wen, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    tick();

    // Factor 3: first frame only arms the controller.
    cfg_write(1'b1, 3'd3);
    chk("cfg_ready_pending", cfg_if.cfg_ready, 0);
    lb0 = lb_cnt;
    vsync_pulse();
    repeat (VACT) line(HACT);
    chk("f1_factor", o_factor, 3);
    chk("f1_cfg_ready", cfg_if.cfg_ready, 1);
    chk("f1_wait_inactive", o_active, 0);
    chk("f1_lb_wen_count", lb_cnt - lb0, 0);

    push(2, 0, 0); push(5, 1, 0); push(2, 0, 1); push(5, 1, 1);
    lb0 = lb_cnt;
    vsync_pulse();
    chk("f2_active", o_active, 1);
    repeat (VACT) line(HACT);
    chk("f2_pulses_done", exp_q.size(), 0);
    chk("f2_lb_wen_count", lb_cnt - lb0, 36);
    chk("f2_done_inactive", o_active, 0);

    // Mid-frame write of factor 2 waits for the next frame.
    push(2, 0, 0); push(5, 1, 0); push(2, 0, 1); push(5, 1, 1);
    vsync_pulse();
    repeat (3) line(HACT);
    cfg_write(1'b1, 3'd2);
    chk("f3_ready_low", cfg_if.cfg_ready, 0);
    chk("f3_factor_kept", o_factor, 3);
    repeat (3) line(HACT);
    chk("f3_ready_still_low", cfg_if.cfg_ready, 0);
    chk("f3_pulses_done", exp_q.size(), 0);

    for (int l = 1; l < VACT; l += 2)
      for (int p = 1; p < HACT; p += 2)
        push(p, p / 2, l / 2);
    vsync_pulse();
    chk("f4_factor", o_factor, 2);
    chk("f4_ready", cfg_if.cfg_ready, 1);
    repeat (VACT) line(HACT);
    chk("f4_pulses_done", exp_q.size(), 0);

    // Factor 4: single window, remainder pixels/lines still written.
    cfg_write(1'b1, 3'd4);
    push(3, 0, 0);
    lb0 = lb_cnt;
    vsync_pulse();
    repeat (VACT) line(HACT);
    chk("f5_factor", o_factor, 4);
    chk("f5_pulses_done", exp_q.size(), 0);
    chk("f5_lb_wen_count", lb_cnt - lb0, 36);

    // Short last line raises err_hlen, which survives a good frame.
    push(3, 0, 0);
    vsync_pulse();
    repeat (VACT - 1) line(HACT);
    line(HACT - 1);
    chk("f6_err_hlen", o_err, 3'b001);
    push(3, 0, 0);
    vsync_pulse();
    repeat (VACT) line(HACT);
    chk("f7_err_hlen_sticky", o_err, 3'b001);
    chk("f7_pulses_done", exp_q.size(), 0);

    // Factor 0 is clamped to 1 and flagged; early vsync flags err_vlen.
    cfg_write(1'b1, 3'd0);
    chk("cfg0_err", o_err, 3'b100);
    for (int l = 0; l < 4; l++)
      for (int p = 0; p < HACT; p++)
        push(p, p, l);
    vsync_pulse();
    chk("f8_factor_clamped", o_factor, 1);
    repeat (4) line(HACT);
    chk("f8_pulses_done", exp_q.size(), 0);
    push(0, 0, 0); push(1, 1, 0); push(2, 2, 0);
    vsync_pulse();
    chk("f9_err_vlen", o_err, 3'b110);

    // Reset in the middle of a line.
    for (int i = 0; i < 3; i++) begin
      i_de = 1'b1;
      tick();
    end
    rstn = 1'b0;
    #1;
    chk("mid_rst_lb_wen", o_lb_wen, 0);
    chk("mid_rst_out_valid", o_out_valid, 0);
    chk("mid_rst_active", o_active, 0);
    chk("mid_rst_err", o_err, 0);
    chk("mid_rst_factor", o_factor, 0);
    chk("mid_rst_addr", o_lb_addr, 0);
    chk("mid_rst_pulses_done", exp_q.size(), 0);
    i_de = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
    vsync_pulse();
    line(HACT);
    chk("post_rst_idle", o_active, 0);
    cfg_write(1'b1, 3'd3);
    vsync_pulse();
    chk("post_rst_wait", o_active, 0);
    vsync_pulse();
    chk("post_rst_active", o_active, 1);

    chk("queue_empty_end", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
